apb_req_arbiter: RTL and testbench

//  Two-requester APB master front end. Round-robin arbitrates queued read/write

---
 rtl/apb_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin two-requester front end issuing one APB transfer per command with timeout abort.
module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*WIDTH-1:0]      req_wdata,
  input  logic [7:0]              req_strb,
  output logic [1:0]              req_ack,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [WIDTH-1:0]        rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic                    psel,
  output logic                    penable,
  output logic [WIDTH-1:0]        pwdata,
  output logic [3:0]              pstrb,
  input  logic [WIDTH-1:0]        prdata,
  input  logic                    pready,
  input  logic                    pslverr
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [3:0] pstrb_q, pstrb_d;
  logic [1:0] req_ack_q, req_ack_d;
  logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d, busy_q, busy_d;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic rsp_timeout_q, rsp_timeout_d;
  logic g, gw, to_hit;
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    busy_d        = busy_q;
    req_ack_d     = '0;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    g      = &req_valid ? ~last_grant_q : req_valid[1];
    gw     = req_write[g];
    to_hit = !pready && TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d      = SETUP;
        last_grant_d = g;
        paddr_d      = g ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        pwrite_d     = gw;
        pwdata_d     = gw ? (g ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0]) : '0;
        pstrb_d      = gw ? (g ? req_strb[7:4] : req_strb[3:0]) : '0;
        psel_d       = 1'b1;
        busy_d       = 1'b1;
        req_ack_d[g] = 1'b1;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: if (pready || to_hit) begin
        state_d       = IDLE;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        busy_d        = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_id_d      = last_grant_q;
        rsp_err_d     = pready ? pslverr : 1'b1;
        rsp_timeout_d = to_hit;
        rsp_rdata_d   = (pready && !pwrite_q && !pslverr) ? prdata : '0;
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      busy_q        <= 1'b0;
      req_ack_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      busy_q        <= busy_d;
      req_ack_q     <= req_ack_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign req_ack     = req_ack_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: table vectors, corner sequences and random traffic against a memory-model APB slave.
module tb_apb_req_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req_valid = '0, req_write = '0, req_ack;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [7:0] req_strb = '0, paddr, pwdata, prdata, rsp_rdata;
  logic [3:0] pstrb;
  logic rsp_valid, rsp_id, rsp_err, rsp_timeout, busy, pwrite, psel, penable, pready, pslverr;
  int n_cmp = 0, n_bad = 0;
  int waits = 0;
  bit err_inj = 0, hang = 0;
  logic [3:0] wcnt = '0;
  logic [7:0] smem [256];
  logic [7:0] ref_mem [256];

  apb_req_arbiter #(.ADDR_WIDTH(8), .WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  always #5 clk = ~clk;

  // slave: `waits` wait states, optional error or permanent stall; stores writes unless erroring
  assign pready  = psel && penable && !hang && int'(wcnt) == waits;
  assign pslverr = pready && err_inj;
  assign prdata  = smem[paddr];
  always @(posedge clk) wcnt <= (psel && penable && !pready) ? wcnt + 4'd1 : 4'd0;
  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 256; i++) smem[i] <= 8'h00;
    else if (psel && penable && pready && pwrite && !err_inj && pstrb != 0) smem[paddr] <= pwdata;

  typedef struct {
    int id; bit w; logic [7:0] a, d; logic [3:0] s; int wt; bit er, hg;
    logic [7:0] xr; bit xe, xt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic clr_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // spec-level prediction of one transfer's outcome
  task automatic model(input bit w, input logic [7:0] a, input int wt, input bit er, input bit hg,
                       output logic [7:0] xr, output bit xe, output bit xt, output int lat);
    xt  = hg || wt >= TO;
    xe  = xt || er;
    xr  = (!w && !xe) ? ref_mem[a] : 8'h00;
    lat = xt ? TO + 1 : wt + 2;
  endtask

  task automatic issue(input int id, input bit w, input logic [7:0] a, input logic [7:0] d,
                       input logic [3:0] s, output bit ok);
    int n = 0;
    req_write[id] = w;
    req_addr[id*8 +: 8] = a;
    req_wdata[id*8 +: 8] = d;
    req_strb[id*4 +: 4] = s;
    req_valid[id] = 1'b1;
    do begin @(negedge clk); n++; end while (!req_ack[id] && n < 20);
    req_valid[id] = 1'b0;
    ok = req_ack[id];
    if (!ok) chk("ack_wait", 0, 1);
  endtask

  task automatic run(input vec_t v, input bit use_tbl);
    logic [7:0] xr; bit xe, xt, ok; int lat, n;
    logic [22:0] bus_exp;
    model(v.w, v.a, v.wt, v.er, v.hg, xr, xe, xt, lat);
    if (use_tbl) begin xr = v.xr; xe = v.xe; xt = v.xt; end
    waits = v.wt; err_inj = v.er; hang = v.hg;
    issue(v.id, v.w, v.a, v.d, v.s, ok);
    if (!ok) return;
    bus_exp = {1'b1, 1'b0, v.a, v.w, v.w ? v.d : 8'h00, v.w ? v.s : 4'h0};
    chk("setup_bus", {psel, penable, paddr, pwrite, pwdata, pstrb}, bus_exp);
    chk("busy", busy, 1);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) chk("access_phase", {psel, penable}, 2'b11);
    end while (!rsp_valid && n < 30);
    chk("latency", n, lat);
    chk("rsp", {rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, v.id[0], xr, xe, xt});
    @(negedge clk);
    chk("rsp_hold", {rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout, psel}, {1'b0, v.id[0], xr, xe, xt, 1'b0});
    if (v.w && !(v.er || v.hg || v.wt >= TO) && v.s != 0) ref_mem[v.a] = v.d;
    waits = 0; err_inj = 0; hang = 0;
  endtask

  initial begin
    bit ok; int n, na, seen;
    int ack_t[4], ack_g[4];
    bit psel_h[64];
    vec_t v;
    clr_ref();
    tbl.push_back('{0, 1'b1, 8'h05, 8'hA5, 4'hF, 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{1, 1'b0, 8'h05, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h05, 8'h00, 4'h0, 0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b1, 8'h10, 8'h3C, 4'h1, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h10, 8'h00, 4'h0, 3, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0});
    tbl.push_back('{0, 1'b1, 8'h05, 8'h11, 4'hF, 0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{1, 1'b0, 8'h05, 8'h00, 4'h0, 0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1});
    tbl.push_back('{1, 1'b0, 8'h05, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0});
    tbl.push_back('{0, 1'b0, 8'h20, 8'h00, 4'h0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    @(negedge clk);
    chk("reset_outputs", {req_ack, rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout, busy,
                          paddr, pwrite, psel, penable, pwdata, pstrb}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    foreach (tbl[i]) run(tbl[i], 1'b1);
    // reset while a transfer is stalled in ACCESS
    hang = 1;
    issue(1, 1'b0, 8'h05, 8'h00, 4'h0, ok);
    @(negedge clk); @(negedge clk);
    chk("pre_reset_access", {psel, penable}, 2'b11);
    rst = 1'b1;
    #1 chk("async_reset_bus", {psel, penable, busy}, 3'b000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; hang = 0; clr_ref();
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); seen += int'(rsp_valid); end
    chk("no_rsp_after_reset", seen, 0);
    // contention: both requesters continuously valid
    req_write = 2'b00; req_addr = 16'h0201; req_valid = 2'b11;
    na = 0; n = 0;
    while (na < 4 && n < 60) begin
      @(negedge clk);
      psel_h[n] = psel;
      if (req_ack != 0) begin ack_t[na] = n; ack_g[na] = int'(req_ack[1]); na++; end
      n++;
    end
    req_valid = 2'b00;
    chk("contention_acks", na, 4);
    for (int k = 0; k < na; k++) chk("grant_order", ack_g[k], k % 2);
    for (int k = 1; k < na; k++) begin
      chk("ack_spacing", ack_t[k] - ack_t[k-1], 3);
      chk("idle_gap_psel", psel_h[ack_t[k] - 1], 0);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
    // random traffic checked against the model
    for (int t = 0; t < 40; t++) begin
      v.id = int'($urandom_range(1, 0));
      v.w  = 1'($urandom_range(1, 0));
      v.a  = 8'($urandom_range(7, 0));
      v.d  = 8'($urandom);
      v.s  = 4'($urandom_range(15, 1));
      v.wt = int'($urandom_range(3, 0));
      v.er = $urandom_range(7, 0) == 0;
      v.hg = $urandom_range(9, 0) == 0;
      v.xr = 8'h00; v.xe = 1'b0; v.xt = 1'b0;
      run(v, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
